// File: rtl/collision_scheduler.sv
// collision_scheduler
// Per-frame sequencer that shares one registered bounding-box overlap comparator across
// NB_CARS car slots. On each enabled frame start it latches the frog position, reads every car
// slot from an external register file (1-cycle read latency), and reports the first overlap.
// After a hit a grace window of GRACE_FRAMES frames suppresses further scans.
//
// Optional feature (macro COLLISION_SCHED_HITMASK_EN): all slots are always scanned, a per-slot
// hit mask is exported on o_Hit_Mask, and a single o_Collision is reported at the end of the scan
// with o_Hit_Idx set to the lowest hitting slot.
//
// Ports:
//   i_Clk, i_Rst_L        clock, asynchronous active-low reset
//   i_Enable              game running; low aborts a scan, freezes grace, blocks new scans
//   i_Frame_Start         one-cycle pulse per frame
//   i_Frog_X/i_Frog_Y     frog top-left position (latched at frame start)
//   o_Car_Rd/o_Car_Idx    car table read strobe and slot
//   i_Car_X/i_Car_Y       car top-left position, valid one cycle after o_Car_Rd
//   o_Collision           one-cycle hit pulse; o_Hit_Idx gives the slot, held until next hit
//   o_Scan_Done           one-cycle pulse when a scan ends without a hit
//   o_Grace, o_Busy       grace window active, scan in progress
//   o_Overrun             sticky: frame start seen while scanning
//   o_Hit_Mask            (feature only) per-slot hit flags of the last scan
module collision_scheduler #(
  parameter int unsigned TILE_SIZE    = 32,
  parameter int unsigned NB_CARS      = 4,
  parameter int unsigned GRACE_FRAMES = 60,
  localparam int unsigned IDX_W = (NB_CARS > 1) ? $clog2(NB_CARS) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  input  logic             i_Frame_Start,
  input  logic [9:0]       i_Frog_X,
  input  logic [9:0]       i_Frog_Y,
  output logic             o_Car_Rd,
  output logic [IDX_W-1:0] o_Car_Idx,
  input  logic [9:0]       i_Car_X,
  input  logic [8:0]       i_Car_Y,
  output logic             o_Collision,
  output logic [IDX_W-1:0] o_Hit_Idx,
  output logic             o_Scan_Done,
  output logic             o_Grace,
  output logic             o_Busy,
  output logic             o_Overrun
`ifdef COLLISION_SCHED_HITMASK_EN
  ,
  output logic [NB_CARS-1:0] o_Hit_Mask
`endif
);

  localparam int unsigned CNT_W = $clog2(NB_CARS + 1);
  localparam int unsigned GR_W  = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

  localparam logic [10:0]      TileW     = 11'(TILE_SIZE);
  localparam logic [CNT_W-1:0] NbCnt     = CNT_W'(NB_CARS);
  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NB_CARS - 1);
  localparam logic [GR_W-1:0]  GraceLoad = GR_W'(GRACE_FRAMES);

  typedef enum logic [1:0] {StIdle, StScan, StGrace} state_e;

  state_e           r_state, w_state_nxt;
  logic [9:0]       r_frog_x, r_frog_y;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_cap_vld;           // car data on i_Car_* this cycle
  logic [IDX_W-1:0] r_cap_idx;
  logic             r_res_vld, r_res_hit; // registered comparator result
  logic [IDX_W-1:0] r_res_idx;
  logic [IDX_W-1:0] r_hit_idx;
  logic [GR_W-1:0]  r_grace_cnt;
  logic             r_overrun;

  logic             w_start, w_rd, w_hit, w_coll, w_done, w_res_last;
  logic [IDX_W-1:0] w_coll_idx;
  logic [10:0]      w_fx, w_fy, w_cx, w_cy;

  assign w_start    = (r_state == StIdle) && i_Frame_Start && i_Enable;
  assign w_res_last = r_res_vld && (r_res_idx == LastIdx);

  // 11-bit unsigned overlap test; touching edges are not a hit.
  assign w_fx  = {1'b0, r_frog_x};
  assign w_fy  = {1'b0, r_frog_y};
  assign w_cx  = {1'b0, i_Car_X};
  assign w_cy  = {2'b00, i_Car_Y};
  assign w_hit = (w_fx < w_cx + TileW) && (w_cx < w_fx + TileW) &&
                 (w_fy < w_cy + TileW) && (w_cy < w_fy + TileW);

`ifdef COLLISION_SCHED_HITMASK_EN
  logic [NB_CARS-1:0] r_hit_mask;
  logic [IDX_W-1:0]   r_first_idx;
  logic [NB_CARS-1:0] w_res_bit;
  logic               w_any;

  assign w_res_bit  = NB_CARS'(1) << r_res_idx;
  // The last slot's result is still in r_res_* when the scan ends.
  assign w_any      = (|r_hit_mask) || (r_res_vld && r_res_hit);
  assign w_rd       = (r_state == StScan) && (r_rd_cnt < NbCnt);
  assign w_coll     = (r_state == StScan) && i_Enable && w_res_last && w_any;
  assign w_done     = (r_state == StScan) && i_Enable && w_res_last && !w_any;
  assign w_coll_idx = (|r_hit_mask) ? r_first_idx : r_res_idx;
  assign o_Hit_Mask = r_hit_mask;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hit_mask  <= '0;
      r_first_idx <= '0;
    end else if (w_start) begin
      r_hit_mask  <= '0;
    end else if ((r_state == StScan) && r_res_vld && r_res_hit) begin
      r_hit_mask <= r_hit_mask | w_res_bit;
      if (r_hit_mask == '0) r_first_idx <= r_res_idx;
    end
  end
`else
  // Reads stop as soon as a registered hit is visible; later results are dropped with SCAN.
  assign w_rd       = (r_state == StScan) && (r_rd_cnt < NbCnt) && !(r_res_vld && r_res_hit);
  assign w_coll     = (r_state == StScan) && i_Enable && r_res_vld && r_res_hit;
  assign w_done     = (r_state == StScan) && i_Enable && w_res_last && !r_res_hit;
  assign w_coll_idx = r_res_idx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StScan;
      StScan: begin
        if (!i_Enable)   w_state_nxt = StIdle;
        else if (w_coll) w_state_nxt = (GRACE_FRAMES == 0) ? StIdle : StGrace;
        else if (w_done) w_state_nxt = StIdle;
      end
      StGrace: begin
        if (i_Frame_Start && i_Enable && (r_grace_cnt <= GR_W'(1))) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= StIdle;
      r_frog_x    <= '0;
      r_frog_y    <= '0;
      r_rd_cnt    <= '0;
      r_cap_vld   <= 1'b0;
      r_cap_idx   <= '0;
      r_res_vld   <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_idx   <= '0;
      r_hit_idx   <= '0;
      r_grace_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cap_vld <= w_rd;
      r_cap_idx <= r_rd_cnt[IDX_W-1:0];
      // Only captures taken while scanning produce a result.
      r_res_vld <= r_cap_vld && (r_state == StScan);
      r_res_hit <= w_hit;
      r_res_idx <= r_cap_idx;
      if (w_start) begin
        r_frog_x <= i_Frog_X;
        r_frog_y <= i_Frog_Y;
        r_rd_cnt <= '0;
      end else if (w_rd) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
      if (w_coll) r_hit_idx <= w_coll_idx;
      if ((r_state == StScan) && (w_state_nxt == StGrace)) begin
        r_grace_cnt <= GraceLoad;
      end else if ((r_state == StGrace) && i_Frame_Start && i_Enable) begin
        r_grace_cnt <= r_grace_cnt - GR_W'(1);
      end
      if ((r_state == StScan) && i_Frame_Start) r_overrun <= 1'b1;
    end
  end

  assign o_Car_Rd    = w_rd;
  assign o_Car_Idx   = w_rd ? r_rd_cnt[IDX_W-1:0] : '0;
  assign o_Collision = w_coll;
  assign o_Hit_Idx   = w_coll ? w_coll_idx : r_hit_idx;
  assign o_Scan_Done = w_done;
  assign o_Grace     = (r_state == StGrace);
  assign o_Busy      = (r_state == StScan);
  assign o_Overrun   = r_overrun;

endmodule
